// File: rtl/seq_log_pkg.sv
// Shared defaults and types for the sequence-match logger.
package seq_log_pkg;

    localparam int unsigned TS_W_DEF  = 16;
    localparam int unsigned DEPTH_DEF = 8;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned DROP_W    = 8;

    typedef logic [TS_W_DEF-1:0] ts_t;

endpackage

// File: rtl/seq_match_logger_if.sv
// Valid/ready stream carrying logged match timestamps from the logger to its consumer.
interface seq_match_logger_if
    import seq_log_pkg::*;
#(
    parameter int unsigned TS_W = TS_W_DEF
);
    logic            out_valid;
    logic            out_ready;
    logic [TS_W-1:0] out_ts;

    modport master (output out_valid, output out_ts, input  out_ready);
    modport slave  (input  out_valid, input  out_ts, output out_ready);

endinterface

// File: rtl/seq_log_fifo.sv
// Show-ahead synchronous FIFO with extra-MSB pointers, synchronous clear and occupancy output.
module seq_log_fifo
    import seq_log_pkg::*;
#(
    parameter int unsigned W     = TS_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == PW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Head is forced to zero while empty so stale storage never shows on the bus
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/seq_match_logger.sv
// Timestamps detector match pulses into a drainable FIFO with saturating count and sticky overflow.
// Optional SEQ_LOG_DROP_CNT_EN adds an 8-bit saturating dropped-match counter (drop_cnt).
module seq_match_logger
    import seq_log_pkg::*;
#(
    parameter int unsigned TS_W  = TS_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr,
    input  logic                   match_i,
    seq_match_logger_if.master     out_if,
    output logic [CNT_W-1:0]       total_cnt,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow
`ifdef SEQ_LOG_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0]      drop_cnt
`endif
);

    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] head_ts;
    logic            push_req;
    logic            pop_req;
    logic            full;
    logic            empty;
    logic            drop;

    assign push_req = en & match_i & ~clr;
    assign pop_req  = out_if.out_ready & ~empty;
    assign drop     = push_req & full & ~pop_req;

    assign out_if.out_valid = ~empty;
    assign out_if.out_ts    = head_ts;

    seq_log_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (push_req),
        .pop   (out_if.out_ready),
        .wdata (ts),
        .rdata (head_ts),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Free-running cycle index; the value logged is the one sampled with the match
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  ts <= '0;
        else if (clr) ts <= '0;
        else if (en)  ts <= ts + TS_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_cnt <= '0;
            overflow  <= 1'b0;
        end else if (clr) begin
            total_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push_req && (total_cnt != '1)) total_cnt <= total_cnt + CNT_W'(1);
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef SEQ_LOG_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         drop_cnt <= '0;
        else if (clr)                       drop_cnt <= '0;
        else if (drop && (drop_cnt != '1))  drop_cnt <= drop_cnt + DROP_W'(1);
    end
`endif

endmodule

// File: tb/tb_seq_match_logger.sv
// Directed bench for seq_match_logger with a queue-based timestamp scoreboard.
module tb_seq_match_logger;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        match_i;
    logic [15:0] total_cnt;
    logic [3:0]  fifo_level;
    logic        overflow;
`ifdef SEQ_LOG_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    seq_match_logger_if #(.TS_W(16)) bus ();

    seq_match_logger #(
        .TS_W  (16),
        .DEPTH (8),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .match_i    (match_i),
        .out_if     (bus.master),
        .total_cnt  (total_cnt),
        .fifo_level (fifo_level),
        .overflow   (overflow)
`ifdef SEQ_LOG_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int unsigned m_ts;
    int unsigned m_total;
    int unsigned m_drop;
    bit          m_ovf;
    logic [15:0] m_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_ts    = 0;
        m_total = 0;
        m_drop  = 0;
        m_ovf   = 1'b0;
        m_q.delete();
    endtask

    // Drive one cycle of inputs, compare current outputs with the model, then advance both.
    task automatic cycle(input logic e, input logic c, input logic m, input logic r);
        bit do_pop;
        bit was_full;
        en = e; clr = c; match_i = m; bus.out_ready = r;
        chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
        chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        chk("total_cnt", 32'(total_cnt), m_total);
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef SEQ_LOG_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), m_drop);
`endif
        if (m_q.size() != 0) chk("out_ts_head", 32'(bus.out_ts), 32'(m_q[0]));
        if (c) begin
            model_clear();
        end else begin
            do_pop   = (m_q.size() != 0) && r;
            was_full = (m_q.size() == 8);
            if (do_pop) void'(m_q.pop_front());
            if (e && m) begin
                if (m_total != 32'hFFFF) m_total++;
                if (!was_full || do_pop) m_q.push_back(16'(m_ts));
                else begin
                    m_ovf = 1'b1;
                    if (m_drop != 255) m_drop++;
                end
            end
            if (e) m_ts = (m_ts + 1) & 32'hFFFF;
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_ts"},    32'(bus.out_ts),    32'd0);
        chk({tag, "_level"}, 32'(fifo_level),    32'd0);
        chk({tag, "_total"}, 32'(total_cnt),     32'd0);
        chk({tag, "_ovf"},   32'(overflow),      32'd0);
`ifdef SEQ_LOG_DROP_CNT_EN
        chk({tag, "_drop"},  32'(drop_cnt),      32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; match_i = 1'b0; bus.out_ready = 1'b0;
        model_clear();
        @(posedge clk); #1;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: matches at cycles 3 and 7, consumer always ready
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, (i == 3) || (i == 7), 1'b1);
            if (i == 3) begin
                chk("t1_valid_after3", 32'(bus.out_valid), 32'd1);
                chk("t1_ts3", 32'(bus.out_ts), 32'd3);
            end
            if (i == 4) chk("t1_valid_one_cycle", 32'(bus.out_valid), 32'd0);
            if (i == 7) chk("t1_ts7", 32'(bus.out_ts), 32'd7);
        end
        chk("t1_total", 32'(total_cnt), 32'd2);
        chk("t1_ovf", 32'(overflow), 32'd0);

        // 2: ten matches into a stalled FIFO of eight
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t2_level", 32'(fifo_level), 32'd8);
        chk("t2_ovf", 32'(overflow), 32'd1);
        chk("t2_total", 32'(total_cnt), 32'd10);
`ifdef SEQ_LOG_DROP_CNT_EN
        chk("t2_drop", 32'(drop_cnt), 32'd2);
`endif
        for (int i = 0; i < 8; i++) begin
            chk("t2_drain", 32'(bus.out_ts), 32'(i));
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("t2_empty", 32'(fifo_level), 32'd0);

        // 3: full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t3_level", 32'(fifo_level), 32'd8);
        chk("t3_head", 32'(bus.out_ts), 32'd11);
        chk("t3_ovf", 32'(overflow), 32'd1);
`ifdef SEQ_LOG_DROP_CNT_EN
        chk("t3_drop", 32'(drop_cnt), 32'd2);
`endif

        // 5: clear with a same-cycle match while entries are queued
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_level3", 32'(fifo_level), 32'd3);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5_level", 32'(fifo_level), 32'd0);
        chk("t5_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_total", 32'(total_cnt), 32'd0);
        chk("t5_ovf", 32'(overflow), 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t5_ts_zero", 32'(bus.out_ts), 32'd0);
        chk("t5_level1", 32'(fifo_level), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // 4: timestamp wrap from 0xFFFF to 0x0000
        while (m_ts != 32'hFFFE) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_level", 32'(fifo_level), 32'd2);
        chk("t4_ffff", 32'(bus.out_ts), 32'hFFFF);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_wrap", 32'(bus.out_ts), 32'h0000);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // 6: en low ignores matches and freezes ts
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_total", 32'(total_cnt), 32'd3);
        chk("t6_level", 32'(fifo_level), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t6_frozen_ts", 32'(bus.out_ts), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a drain cycle
        en = 1'b0; match_i = 1'b0; bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("post_rst_ts", 32'(bus.out_ts), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
